spmv_issue_ctrl: RTL and testbench
==================================

# spmv_issue_ctrl

Issue controller for the sparse matrix-vector MAC pipeline. It holds the dense input vector in a small register file and accepts a stream of nonzero matrix entries, one per cycle. It packs the entries into K-lane groups that never span rows, issues each group to the multiply/reduce datapath, and tracks in-flight groups across the fixed datapath latency to report row completion and job completion.

## Interface
- K, 4, number of lanes per issued group
- N, 16, vector length (columns)
- IDXW, 4, column index width; N ≤ 2^IDXW
- ROWW, 8, row counter width
- LAT, 4, datapath cycles from issue to reduced row result
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a job; honoured only in IDLE
- row_count  in  ROWW  number of rows in the job; latched on an accepted start
- vec_we  in  1  vector write enable; honoured only in IDLE
- vec_waddr  in  IDXW  vector write address
- vec_wdata  in  8  vector element, signed
- nz_valid  in  1  nonzero entry present
- nz_ready  out  1  controller accepts an entry this cycle
- nz_val  in  8  matrix element, signed
- nz_col  in  IDXW  column of the element
- nz_last  in  1  entry is the last of its row (an empty row is sent as val 0, col 0, last 1)
- issue_valid  out  1  group valid to datapath
- issue_mat  out  8K  matrix lanes; lane 0 = [8K-1:8K-8]
- issue_vec  out  8K  vector lanes, same packing
- issue_mask  out  K  lane valid; bit K-1 = lane 0
- issue_last  out  1  group closes a row
- row_done  out  1  pulse: row result valid at the datapath output
- row_idx  out  ROWW  index of the completed row
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse: job complete

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on start when row_count ≠ 0. IDLE → DONE on start when row_count = 0.
- RUN → DRAIN in the cycle the entry with nz_last that completes row row_count-1 is accepted.
- DRAIN → DONE when no group is in flight and issue_valid is low.
- DONE → IDLE unconditionally after 1 cycle.
- A vector write in the same cycle as start is committed before any read.
- nz_ready = 1 exactly in RUN. An entry is accepted when nz_valid & nz_ready.
- The controller reads vector[nz_col] combinationally at acceptance.
- Accepted entries fill the collect buffer from lane 0 upward.
- The collect buffer closes when it holds K entries or when the accepted entry has nz_last.
- On close, the buffer moves to the issue register. Collection restarts empty in the next cycle, so back-to-back acceptance never stalls.
- Unused lanes carry mat 0, vec 0, and mask bit 0.
- A K-full group that is not the end of a row has issue_last 0. The row continues in the next group.
- In-flight tracking uses a LAT-deep shift register of (issue_valid & issue_last).
- Its output drives row_done. row_idx starts at 0 per job and increments after each row_done.
- Arithmetic: no products are formed here. row_idx wraps modulo 2^ROWW, and row_count ≤ 2^ROWW-1.
- start in any state other than IDLE is ignored. vec_we outside IDLE is ignored.

## Timing
- Entry accepted at cycle t that closes a group → issue_valid = 1 at t+1 for exactly 1 cycle.
- Group issued at t+1 with issue_last → row_done = 1 at t+1+LAT.
- done = 1 in the cycle after the final row_done. busy is low from the cycle after done.
- Reset values:
  - nz_ready, issue_valid, issue_last, row_done, busy, done are 0.
  - issue_mat, issue_vec, issue_mask, row_idx are 0.
  - The state is IDLE and the shift register is cleared.
- The vector register file is reset to 0.
- Reset mid-job discards the partial group and all in-flight tracking. No row_done or done follows.
- Simultaneous events within one cycle:
  - A K-th entry with nz_last closes one group with issue_last 1.
  - row_done, a new issue, and acceptance may all coincide.

## Test plan
- Load vector[i] = i+1. Start with row_count 1. Send entries (val 2, col 0), (3, col 1), (4, col 5, last).
  - One issue at acceptance+1 with mask 1110, mat {2,3,4,0}, vec {1,2,6,0}, issue_last 1.
  - row_done with row_idx 0 arrives LAT cycles later. done follows 1 cycle after that.
- Row of 6 entries with K=4.
  - Two issues: mask 1111 with last 0, then mask 1100 with last 1.
  - Exactly one row_done.
- Three rows of 4, 1, and 0 entries (empty row sent as 0, 0, last), with continuous nz_valid.
  - nz_ready stays high throughout.
  - Issues have masks 1111, 1000, 1000, each with last 1.
  - row_idx 0, 1, 2 on consecutive-spaced row_done.
- start with row_count 0 → done at +1, no issue. Also: vec_we and start in RUN → no effect on vector contents or row count.
- rst asserted 2 cycles after a group issue.
  - All outputs are 0 next cycle; no row_done appears over 2·LAT cycles.
  - A fresh job then completes correctly.

Source files
------------

// File: rtl/spmv_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spmv_issue_ctrl
//  Description : Issue controller for the sparse matrix-vector MAC pipeline.
//                Holds the dense vector in a register file, packs incoming
//                nonzero entries into K-lane groups that never span rows,
//                issues them to the datapath and tracks in-flight rows across
//                the fixed datapath latency to report row and job completion.
//  Ports       :
//    clk, rst          clock, synchronous active-high reset
//    start, row_count  job start (honoured in IDLE) and number of rows
//    vec_we/waddr/wdata vector register file write port (IDLE only)
//    nz_valid/ready    nonzero entry handshake (ready exactly in RUN)
//    nz_val/col/last   matrix element, column, end-of-row flag
//    issue_*           registered group to the datapath (lane 0 in MSBs)
//    row_done, row_idx row result valid at datapath output, its row index
//    busy, done        job in progress, one-cycle job-complete pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module spmv_issue_ctrl #(
    parameter int K    = 4,
    parameter int N    = 16,
    parameter int IDXW = 4,
    parameter int ROWW = 8,
    parameter int LAT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROWW-1:0]   row_count,
    input  logic              vec_we,
    input  logic [IDXW-1:0]   vec_waddr,
    input  logic [7:0]        vec_wdata,
    input  logic              nz_valid,
    output logic              nz_ready,
    input  logic [7:0]        nz_val,
    input  logic [IDXW-1:0]   nz_col,
    input  logic              nz_last,
    output logic              issue_valid,
    output logic [8*K-1:0]    issue_mat,
    output logic [8*K-1:0]    issue_vec,
    output logic [K-1:0]      issue_mask,
    output logic              issue_last,
    output logic              row_done,
    output logic [ROWW-1:0]   row_idx,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(K + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;

    logic [7:0]      r_vec [N];
    logic [ROWW-1:0] r_row_cnt;
    logic [ROWW-1:0] r_rows_acc;
    logic [ROWW-1:0] r_row_idx;

    logic [7:0]      r_cmat [K];
    logic [7:0]      r_cvec [K];
    logic [CW-1:0]   r_ccnt;

    logic [LAT-1:0]  r_sr;

    logic            w_accept;
    logic            w_start_ok;
    logic            w_close;
    logic            w_final_row;
    logic            w_tail_busy;
    logic [7:0]      w_vec_rd;
    logic [7:0]      w_lane_mat [K];
    logic [7:0]      w_lane_vec [K];
    logic [K-1:0]    w_lane_msk;
    logic [8*K-1:0]  w_pack_mat;
    logic [8*K-1:0]  w_pack_vec;
    logic [K-1:0]    w_pack_msk;

    assign w_accept    = nz_valid & nz_ready;
    assign w_start_ok  = start && (r_state == c_ST_IDLE);
    assign w_close     = w_accept && (nz_last || (r_ccnt == CW'(K - 1)));
    assign w_final_row = w_accept && nz_last && (r_rows_acc == (r_row_cnt - ROWW'(1)));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Rows still in flight other than the one leaving the pipe this cycle.
    // Looking past the head lets done land in the cycle after the final
    // row_done rather than one cycle later.
    always_comb begin
        w_tail_busy = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            w_tail_busy = w_tail_busy | r_sr[i];
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (row_count == '0) ? c_ST_DONE : c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_final_row) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (!issue_valid && !w_tail_busy) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        nz_ready = (r_state == c_ST_RUN);
        busy     = (r_state != c_ST_IDLE);
        done     = (r_state == c_ST_DONE);
    end

    // ------------------------------------------------------------------
    // Vector register file; writes only land while idle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_vec[i] <= '0;
            end
        end else if ((r_state == c_ST_IDLE) && vec_we) begin
            for (int i = 0; i < N; i++) begin
                if (IDXW'(i) == vec_waddr) begin
                    r_vec[i] <= vec_wdata;
                end
            end
        end
    end

    // Out-of-range columns read as zero when N < 2^IDXW.
    always_comb begin
        w_vec_rd = '0;
        for (int i = 0; i < N; i++) begin
            if (IDXW'(i) == nz_col) begin
                w_vec_rd = r_vec[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Collect buffer view including the entry being accepted this cycle
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < K; i++) begin
            w_lane_mat[i] = r_cmat[i];
            w_lane_vec[i] = r_cvec[i];
            w_lane_msk[i] = (CW'(i) < r_ccnt);
            if (w_accept && (CW'(i) == r_ccnt)) begin
                w_lane_mat[i] = nz_val;
                w_lane_vec[i] = w_vec_rd;
                w_lane_msk[i] = 1'b1;
            end
        end
    end

    // Lane 0 sits in the most significant byte / mask bit.
    always_comb begin
        w_pack_mat = '0;
        w_pack_vec = '0;
        w_pack_msk = '0;
        for (int i = 0; i < K; i++) begin
            w_pack_mat[8*(K-1-i) +: 8] = w_lane_mat[i];
            w_pack_vec[8*(K-1-i) +: 8] = w_lane_vec[i];
            w_pack_msk[K-1-i]          = w_lane_msk[i];
        end
    end

    // Buffer empties on close so collection restarts without a stall and
    // unused lanes of the next group read back as zero.
    always_ff @(posedge clk) begin
        if (rst || w_close) begin
            for (int i = 0; i < K; i++) begin
                r_cmat[i] <= '0;
                r_cvec[i] <= '0;
            end
            r_ccnt <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < K; i++) begin
                if (CW'(i) == r_ccnt) begin
                    r_cmat[i] <= nz_val;
                    r_cvec[i] <= w_vec_rd;
                end
            end
            r_ccnt <= r_ccnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Issue register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid <= 1'b0;
            issue_mat   <= '0;
            issue_vec   <= '0;
            issue_mask  <= '0;
            issue_last  <= 1'b0;
        end else begin
            issue_valid <= w_close;
            if (w_close) begin
                issue_mat  <= w_pack_mat;
                issue_vec  <= w_pack_vec;
                issue_mask <= w_pack_msk;
                issue_last <= nz_last;
            end else begin
                issue_last <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // In-flight row tracking across the datapath latency
    // ------------------------------------------------------------------
    generate
        if (LAT == 1) begin : g_sr_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= issue_valid & issue_last;
                end
            end
        end else begin : g_sr_chain
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= {r_sr[LAT-2:0], issue_valid & issue_last};
                end
            end
        end
    endgenerate

    assign row_done = r_sr[LAT-1];
    assign row_idx  = r_row_idx;

    // ------------------------------------------------------------------
    // Job bookkeeping: latched row count, rows accepted, completed index
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_cnt  <= '0;
            r_rows_acc <= '0;
            r_row_idx  <= '0;
        end else if (w_start_ok) begin
            r_row_cnt  <= row_count;
            r_rows_acc <= '0;
            r_row_idx  <= '0;
        end else begin
            if (w_accept && nz_last) begin
                r_rows_acc <= r_rows_acc + ROWW'(1);
            end
            if (row_done) begin
                r_row_idx <= r_row_idx + ROWW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spmv_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spmv_issue_ctrl
//  Description : Scoreboard bench for spmv_issue_ctrl. A driver sends jobs and
//                pushes expected groups, row completions and done pulses into
//                queues; an independent monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spmv_issue_ctrl;

    localparam int K    = 4;
    localparam int N    = 16;
    localparam int IDXW = 4;
    localparam int ROWW = 8;
    localparam int LAT  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [ROWW-1:0] row_count = '0;
    logic            vec_we = 1'b0;
    logic [IDXW-1:0] vec_waddr = '0;
    logic [7:0]      vec_wdata = '0;
    logic            nz_valid = 1'b0;
    logic            nz_ready;
    logic [7:0]      nz_val = '0;
    logic [IDXW-1:0] nz_col = '0;
    logic            nz_last = 1'b0;
    logic            issue_valid;
    logic [8*K-1:0]  issue_mat;
    logic [8*K-1:0]  issue_vec;
    logic [K-1:0]    issue_mask;
    logic            issue_last;
    logic            row_done;
    logic [ROWW-1:0] row_idx;
    logic            busy;
    logic            done;

    spmv_issue_ctrl #(.K(K), .N(N), .IDXW(IDXW), .ROWW(ROWW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .row_count(row_count),
        .vec_we(vec_we), .vec_waddr(vec_waddr), .vec_wdata(vec_wdata),
        .nz_valid(nz_valid), .nz_ready(nz_ready), .nz_val(nz_val),
        .nz_col(nz_col), .nz_last(nz_last),
        .issue_valid(issue_valid), .issue_mat(issue_mat), .issue_vec(issue_vec),
        .issue_mask(issue_mask), .issue_last(issue_last),
        .row_done(row_done), .row_idx(row_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [8*K-1:0] mat;
        logic [8*K-1:0] vec;
        logic [K-1:0]   mask;
        logic           last;
        int             cy;
    } iss_t;

    typedef struct {
        int idx;
        int cy;
    } rd_t;

    iss_t exp_iss [$];
    rd_t  exp_rd [$];
    int   exp_done [$];

    logic [7:0] mvec [N];
    int  jv [$];
    int  jc [$];
    bit  jl [$];
    int  jrows;
    int  last_iss_cy;
    int  spurious = 0;
    bit  prev_done = 1'b0;
    iss_t m_e;
    rd_t  m_r;
    int   m_d;

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst) begin
            if (issue_valid) begin
                tests++;
                if (exp_iss.size() == 0) begin
                    fails++; spurious++;
                    $display("FAIL issue_unexpected cyc=%0d mat=%h mask=%b", cyc, issue_mat, issue_mask);
                end else begin
                    m_e = exp_iss.pop_front();
                    if ({issue_mat, issue_vec, issue_mask, issue_last} !== {m_e.mat, m_e.vec, m_e.mask, m_e.last} || cyc != m_e.cy) begin
                        fails++;
                        $display("FAIL issue got mat=%h vec=%h mask=%b last=%b cyc=%0d want mat=%h vec=%h mask=%b last=%b cyc=%0d",
                                 issue_mat, issue_vec, issue_mask, issue_last, cyc, m_e.mat, m_e.vec, m_e.mask, m_e.last, m_e.cy);
                    end
                end
            end
            if (row_done) begin
                tests++;
                if (exp_rd.size() == 0) begin
                    fails++; spurious++;
                    $display("FAIL row_done_unexpected cyc=%0d row_idx=%0d", cyc, row_idx);
                end else begin
                    m_r = exp_rd.pop_front();
                    if (row_idx !== ROWW'(m_r.idx) || cyc != m_r.cy) begin
                        fails++;
                        $display("FAIL row_done got idx=%0d cyc=%0d want idx=%0d cyc=%0d", row_idx, cyc, m_r.idx, m_r.cy);
                    end
                end
            end
            if (done) begin
                tests++;
                if (exp_done.size() == 0) begin
                    fails++; spurious++;
                    $display("FAIL done_unexpected cyc=%0d", cyc);
                end else begin
                    m_d = exp_done.pop_front();
                    if (cyc != m_d) begin
                        fails++;
                        $display("FAIL done_time got cyc=%0d want cyc=%0d", cyc, m_d);
                    end
                end
            end
            if (prev_done) begin
                tests++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL busy_after_done got %b want 0", busy);
                end
            end
        end
        prev_done = done;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d want completion", cyc);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic clear_job(input int rows);
        jv.delete(); jc.delete(); jl.delete();
        jrows = rows;
    endtask

    task automatic push_ent(input int v, input int c, input bit l);
        jv.push_back(v); jc.push_back(c); jl.push_back(l);
    endtask

    task automatic build_random();
        int len;
        clear_job($urandom_range(1, 5));
        for (int r = 0; r < jrows; r++) begin
            len = $urandom_range(0, 9);
            if (len == 0) push_ent(0, 0, 1'b1);
            else for (int i = 0; i < len; i++)
                push_ent($urandom_range(0, 255), $urandom_range(0, N - 1), i == len - 1);
        end
    endtask

    task automatic load_vec(input bit rnd);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            vec_we    = 1'b1;
            vec_waddr = IDXW'(i);
            vec_wdata = rnd ? 8'($urandom) : 8'(i + 1);
            mvec[i]   = vec_wdata;
        end
        @(negedge clk);
        vec_we = 1'b0;
    endtask

    task automatic check_zero(input string name);
        tests++;
        if ({nz_ready, issue_valid, issue_last, row_done, busy, done, issue_mat, issue_vec, issue_mask, row_idx} !== '0) begin
            fails++;
            $display("FAIL %s outputs got rdy=%b iv=%b il=%b rd=%b busy=%b done=%b mat=%h vec=%h mask=%b idx=%0d want all 0",
                     name, nz_ready, issue_valid, issue_last, row_done, busy, done, issue_mat, issue_vec, issue_mask, row_idx);
        end
    endtask

    task automatic run_job(input int bubbles, input bit chk_ready, input bit junk, input bit stwr, input int abort_n);
        int c, j, g0, ridx, rowstart, tries, n, a;
        bit acc;
        iss_t e;
        rd_t r;
        n = jv.size();
        tries = 0;
        @(negedge clk);
        while (busy && tries < 100) begin @(negedge clk); tries++; end
        start = 1'b1;
        row_count = ROWW'(jrows);
        if (stwr) begin
            a = $urandom_range(0, N - 1);
            vec_we = 1'b1; vec_waddr = IDXW'(a); vec_wdata = 8'($urandom);
            mvec[a] = vec_wdata;
        end
        c = cyc;
        if (jrows == 0) exp_done.push_back(c + 1);
        @(negedge clk);
        start = 1'b0; vec_we = 1'b0;
        ridx = 0; rowstart = 0;
        for (int k = 0; k < n; k++) begin
            if (abort_n > 0 && k == abort_n) break;
            acc = 1'b0; tries = 0;
            while (!acc) begin
                if (bubbles > 0 && $urandom_range(0, 99) < bubbles) begin
                    nz_valid = 1'b0;
                end else begin
                    nz_valid = 1'b1; nz_val = 8'(jv[k]); nz_col = IDXW'(jc[k]); nz_last = jl[k];
                    if (junk) begin
                        start = 1'($urandom_range(0, 1)); row_count = ROWW'($urandom);
                        vec_we = 1'b1; vec_waddr = IDXW'($urandom); vec_wdata = 8'($urandom);
                    end
                    if (chk_ready) begin
                        tests++;
                        if (nz_ready !== 1'b1) begin
                            fails++;
                            $display("FAIL nz_ready_cont got %b want 1 cyc=%0d", nz_ready, cyc);
                        end
                    end
                    if (nz_ready) begin acc = 1'b1; c = cyc; end
                end
                if (!acc) begin
                    tries++;
                    if (tries > 200) begin
                        fails++;
                        $display("FAIL accept_timeout entry=%0d got nz_ready=%b want 1", k, nz_ready);
                        $display("[TB] %0d tests run, %0d failed", tests, fails);
                        $fatal(1, "entry never accepted");
                    end
                    @(negedge clk);
                end
            end
            j = k - rowstart;
            if (jl[k] || (j % K) == K - 1) begin
                g0 = k - (j % K);
                e.mat = '0; e.vec = '0; e.mask = '0; e.last = jl[k]; e.cy = c + 1;
                for (int l = 0; l < K; l++) begin
                    if (g0 + l <= k) begin
                        e.mat[8*(K-1-l) +: 8] = 8'(jv[g0 + l]);
                        e.vec[8*(K-1-l) +: 8] = mvec[jc[g0 + l]];
                        e.mask[K-1-l] = 1'b1;
                    end
                end
                exp_iss.push_back(e);
                last_iss_cy = c + 1;
                if (jl[k]) begin
                    r.idx = ridx; r.cy = c + 1 + LAT;
                    exp_rd.push_back(r);
                    ridx++;
                    if (ridx == jrows) exp_done.push_back(c + 2 + LAT);
                end
            end
            if (jl[k]) rowstart = k + 1;
            @(negedge clk);
            start = 1'b0; vec_we = 1'b0; nz_valid = 1'b0;
        end
        nz_valid = 1'b0;
        if (abort_n == 0) begin
            tries = 0;
            while ((exp_iss.size() + exp_rd.size() + exp_done.size()) != 0 && tries < 300) begin
                @(negedge clk); tries++;
            end
            tests++;
            if ((exp_iss.size() + exp_rd.size() + exp_done.size()) != 0) begin
                fails++;
                $display("FAIL job_complete got pending iss=%0d rd=%0d done=%0d want 0", exp_iss.size(), exp_rd.size(), exp_done.size());
                exp_iss.delete(); exp_rd.delete(); exp_done.delete();
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < N; i++) mvec[i] = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Partial group of three entries closed by nz_last
        load_vec(1'b0);
        clear_job(1);
        push_ent(2, 0, 1'b0); push_ent(3, 1, 1'b0); push_ent(4, 5, 1'b1);
        run_job(0, 1'b1, 1'b0, 1'b0, 0);

        // Row of six entries: full group then two-lane group
        clear_job(1);
        for (int i = 0; i < 6; i++) push_ent(10 + i, i, i == 5);
        run_job(0, 1'b1, 1'b0, 1'b0, 0);

        // Rows of 4, 1 and 0 entries with continuous valid
        clear_job(3);
        for (int i = 0; i < 4; i++) push_ent(20 + i, 15 - i, i == 3);
        push_ent(7, 9, 1'b1);
        push_ent(0, 0, 1'b1);
        run_job(0, 1'b1, 1'b0, 1'b0, 0);

        // Empty job
        clear_job(0);
        run_job(0, 1'b0, 1'b0, 1'b0, 0);

        // start and vec_we during RUN must be ignored
        clear_job(2);
        for (int i = 0; i < 5; i++) push_ent(30 + i, i * 3, i == 4);
        for (int i = 0; i < 3; i++) push_ent(40 + i, i + 2, i == 2);
        run_job(0, 1'b0, 1'b1, 1'b0, 0);
        clear_job(1);
        for (int i = 0; i < N; i++) push_ent(1, i, i == N - 1);
        run_job(0, 1'b0, 1'b0, 1'b0, 0);

        // Reset two cycles after a row-closing issue
        clear_job(3);
        for (int i = 0; i < 9; i++) push_ent(50 + i, i, (i % 3) == 2);
        run_job(0, 1'b0, 1'b0, 1'b0, 4);
        while (cyc < last_iss_cy + 2) @(negedge clk);
        rst = 1'b1;
        exp_iss.delete(); exp_rd.delete(); exp_done.delete();
        for (int i = 0; i < N; i++) mvec[i] = '0;
        @(negedge clk);
        check_zero("mid_job_reset");
        rst = 1'b0;
        spurious = 0;
        repeat (2 * LAT) @(negedge clk);
        tests++;
        if (spurious != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_quiet got spurious=%0d busy=%b want 0 and 0", spurious, busy);
        end
        clear_job(2);
        for (int i = 0; i < 3; i++) push_ent(60 + i, i, i == 2);
        push_ent(5, 4, 1'b1);
        run_job(0, 1'b0, 1'b0, 1'b0, 0);
        load_vec(1'b0);
        clear_job(1);
        push_ent(2, 0, 1'b0); push_ent(3, 1, 1'b0); push_ent(4, 5, 1'b1);
        run_job(0, 1'b0, 1'b0, 1'b0, 0);

        // Randomised jobs
        for (int t = 0; t < 30; t++) begin
            if (t % 6 == 0) load_vec(1'b1);
            if ($urandom_range(0, 7) == 0) clear_job(0);
            else build_random();
            run_job((t % 2) ? 30 : 0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
